// File: rtl/demux_stream.sv
// 1-to-N valid/ready stream demultiplexer with a one-entry holding register per output channel.
// Optional build macro DEMUX_STREAM_STATS_EN adds a saturating 16-bit accept counter port.
module demux_stream #(
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned SEL_BITS = 2,
  localparam int unsigned NUM_OUT  = 2 ** SEL_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [SEL_BITS-1:0]        in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_OUT*WIDTH-1:0]   out_data,
  output logic [NUM_OUT-1:0]         out_valid,
  input  logic [NUM_OUT-1:0]         out_ready
`ifdef DEMUX_STREAM_STATS_EN
  ,
  output logic [15:0]                accept_count
`endif
);

  logic [NUM_OUT-1:0]            full;
  logic [NUM_OUT-1:0][WIDTH-1:0] hold;
  logic                          acc;

  // A channel takes a new word when empty or when its current word drains this cycle.
  always_comb begin
    in_ready = !full[in_sel] | out_ready[in_sel];
    acc      = in_valid & in_ready;
  end

  // Per-channel holding registers: load on accept, clear on drain without refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
      hold <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_OUT); k++) begin
        if (acc && (in_sel == SEL_BITS'(k))) begin
          hold[k] <= in_data;
          full[k] <= 1'b1;
        end else if (out_ready[k]) begin
          full[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = full;
  assign out_data  = hold;

`ifdef DEMUX_STREAM_STATS_EN
  // Saturating count of accepted input words.
  always_ff @(posedge clk) begin
    if (reset) begin
      accept_count <= 16'h0000;
    end else if (acc && (accept_count != 16'hFFFF)) begin
      accept_count <= accept_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Randomized and directed bench for demux_stream against a per-channel queue model.
module tb_demux_stream;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
`ifdef DEMUX_STREAM_STATS_EN
  logic [15:0]  accept_count;
  int           exp_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference: words accepted but not yet drained, and the last word written per channel.
  logic [31:0] mq[4][$];
  logic [31:0] last_data[4];
  logic        exp_rdy;
  logic        last_acc;

  demux_stream #(.WIDTH(32), .SEL_BITS(2)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_sel(in_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef DEMUX_STREAM_STATS_EN
    ,
    .accept_count(accept_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      last_data[k] = 32'h0;
    end
`ifdef DEMUX_STREAM_STATS_EN
    exp_cnt = 0;
`endif
  endtask

  // Drive inputs, then compare DUT outputs with the model before the next edge.
  task automatic drive(input logic [31:0] d, input logic [1:0] s, input logic v, input logic [3:0] r);
    logic [3:0]   ev;
    logic [127:0] ed;
    in_data = d; in_sel = s; in_valid = v; out_ready = r;
    #1;
    for (int k = 0; k < 4; k++) begin
      ev[k] = (mq[k].size() > 0);
      ed[k*32 +: 32] = last_data[k];
    end
    exp_rdy = (mq[s].size() == 0) || r[s];
    check("out_valid", 128'(out_valid), 128'(ev));
    check("out_data", out_data, ed);
    check("in_ready", 128'(in_ready), 128'(exp_rdy));
`ifdef DEMUX_STREAM_STATS_EN
    check("accept_count", 128'(accept_count), 128'(exp_cnt));
`endif
  endtask

  // Advance one edge and apply drains then the accept to the model.
  task automatic tick();
    logic [31:0] d;
    logic [1:0]  s;
    logic [3:0]  r;
    d = in_data; s = in_sel; r = out_ready;
    last_acc = in_valid && exp_rdy;
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (mq[k].size() > 0 && r[k]) void'(mq[k].pop_front());
    if (last_acc) begin
      mq[s].push_back(d);
      last_data[s] = d;
`ifdef DEMUX_STREAM_STATS_EN
      if (exp_cnt < 65535) exp_cnt++;
`endif
    end
    #1;
  endtask

  task automatic cyc(input logic [31:0] d, input logic [1:0] s, input logic v, input logic [3:0] r);
    drive(d, s, v, r);
    tick();
  endtask

  task automatic do_reset(input int n);
    in_valid = 1'b0; out_ready = 4'b0000; in_data = 32'h0; in_sel = 2'd0;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [31:0] cd;
    logic [1:0]  cs;
    logic        cv;
    logic [3:0]  cr;
    model_clear();
    do_reset(2);

    // Reset then idle: every select reports ready.
    for (int s = 0; s < 4; s++) begin
      drive(32'h0, 2'(s), 1'b0, 4'b0000);
      check("rst_ready", 128'(in_ready), 128'(1'b1));
      tick();
    end

    // Single route to channel 2.
    cyc(32'hDEADBEEF, 2'd2, 1'b1, 4'b0000);
    drive(32'h0, 2'd2, 1'b0, 4'b0000);
    check("route_valid", 128'(out_valid), 128'(4'b0100));
    check("route_data", 128'(out_data[95:64]), 128'(32'hDEADBEEF));
    check("route_rdy_full", 128'(in_ready), 128'(1'b0));
    drive(32'h0, 2'd0, 1'b0, 4'b0000);
    check("route_rdy_other", 128'(in_ready), 128'(1'b1));
    cyc(32'h0, 2'd0, 1'b0, 4'b0100);

    // Back-to-back streaming on channel 1.
    for (int i = 1; i <= 8; i++) begin
      drive(32'(i), 2'd1, 1'b1, 4'b0010);
      check("b2b_ready", 128'(in_ready), 128'(1'b1));
      if (i > 1) check("b2b_data", 128'(out_data[63:32]), 128'(32'(i - 1)));
      tick();
    end
    drive(32'h0, 2'd1, 1'b0, 4'b0010);
    check("b2b_last", 128'(out_data[63:32]), 128'(32'd8));
    tick();

    // Stall and release on channel 3.
    cyc(32'hA5A5A5A5, 2'd3, 1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      drive(32'h5A5A5A5A, 2'd3, 1'b1, 4'b0000);
      check("stall_ready", 128'(in_ready), 128'(1'b0));
      check("stall_data", 128'(out_data[127:96]), 128'(32'hA5A5A5A5));
      tick();
    end
    drive(32'h5A5A5A5A, 2'd3, 1'b1, 4'b1000);
    check("release_ready", 128'(in_ready), 128'(1'b1));
    tick();
    drive(32'h0, 2'd3, 1'b0, 4'b0000);
    check("release_data", 128'(out_data[127:96]), 128'(32'h5A5A5A5A));
    tick();
    cyc(32'h0, 2'd0, 1'b0, 4'b1000);

    // Isolation: channel 0 stalled, channels 1 and 2 stream.
    cyc(32'h0C0C0C0C, 2'd0, 1'b1, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      drive(32'h100 + 32'(i), (i % 2 == 0) ? 2'd1 : 2'd2, 1'b1, 4'b0110);
      check("iso_ready", 128'(in_ready), 128'(1'b1));
      tick();
    end
    drive(32'h0, 2'd0, 1'b0, 4'b0110);
    check("iso_ch0", 128'(out_data[31:0]), 128'(32'h0C0C0C0C));
    check("iso_ch2", 128'(out_data[95:64]), 128'(32'h109));
    tick();

    // Reset mid-operation with all channels full.
    for (int k = 0; k < 4; k++) cyc(32'hF0 + 32'(k), 2'(k), 1'b1, 4'b0000);
    do_reset(1);
    drive(32'h0, 2'd0, 1'b0, 4'b1111);
    check("midrst_valid", 128'(out_valid), 128'(4'b0000));
    tick();
    cyc(32'h0, 2'd0, 1'b0, 4'b1111);

    // Randomized traffic; producer holds an offered word until accepted.
    cd = $urandom; cs = 2'($urandom_range(0, 3)); cv = 1'($urandom); cr = 4'($urandom);
    for (int i = 0; i < 600; i++) begin
      cyc(cd, cs, cv, cr);
      if (!cv || last_acc) begin
        cd = $urandom; cs = 2'($urandom_range(0, 3)); cv = ($urandom_range(0, 3) != 0);
      end
      cr = 4'($urandom);
    end

`ifdef DEMUX_STREAM_STATS_EN
    do_reset(1);
    drive(32'h0, 2'd0, 1'b0, 4'b0000);
    check("cnt_reset", 128'(accept_count), 128'(16'h0));
    for (int i = 0; i < 70000; i++) cyc(32'(i), 2'(i), 1'b1, 4'b1111);
    drive(32'h0, 2'd0, 1'b0, 4'b1111);
    check("cnt_sat", 128'(accept_count), 128'(16'hFFFF));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- 1-to-N stream demultiplexer: steers a WIDTH-bit word from one valid/ready input to the output channel chosen by a select field. It is the distribution-side counterpart of the datapath select muxes.
- Each output channel has a one-entry holding register. Input-to-output latency is 1 cycle, and each channel sustains full throughput.
- Sits between a producer (writeback/bus stage) and N independent consumers.

Parameters:
- WIDTH, 32, data word width in bits
- SEL_BITS, 2, select width; NUM_OUT = 2**SEL_BITS output channels (derived localparam)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  input word
- in_sel  input  SEL_BITS  destination channel index for in_data
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the word addressed by in_sel
- out_data  output  NUM_OUT*WIDTH  flattened per-channel data; channel k occupies bits [k*WIDTH +: WIDTH]
- out_valid  output  NUM_OUT  per-channel word valid
- out_ready  input  NUM_OUT  per-channel consumer ready

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- State per channel k: full[k] (1 bit) and buf[k] (WIDTH bits). out_valid[k] = full[k], and out_data slice k = buf[k].
- Reset: on a clk edge with reset=1, all full[k] are cleared and all buf[k] are zeroed. After reset, out_valid=0, out_data=0, and in_ready is determined by the first post-reset cycle (see below). Words held at reset are discarded, not delivered.
- in_ready = !full[in_sel] | out_ready[in_sel]. This is combinational from in_sel and out_ready. It is independent of in_valid, and in_ready must not depend on in_valid.
- Accept: acc = in_valid & in_ready. On the edge, buf[in_sel] <= in_data and full[in_sel] <= 1. The word appears on channel in_sel the next cycle (latency 1).
- Drain: when out_valid[k] & out_ready[k], the word transfers. full[k] clears on the edge unless the same channel accepts a new word that cycle. Simultaneous drain and accept on one channel keeps full[k]=1 and loads the new word. This gives back-to-back throughput of 1 word/cycle/channel.
- Stalled channel: while full[k]=1 and out_ready[k]=0, buf[k] and out_valid[k] hold stable. A word addressed to k sees in_ready=0, and the producer must hold in_data/in_sel/in_valid.
- Other channels are unaffected by a stalled channel. They drain independently every cycle (no head-of-line blocking in the buffers themselves).
- Only one accept occurs per cycle. Any subset of channels may drain in the same cycle.
- Per-channel order is preserved. There is no ordering guarantee across channels.
- in_sel is sampled only when acc=1. Its value is ignored when in_valid=0.
- Data is never dropped, duplicated, or modified.

Optional Feature:
- Macro DEMUX_STREAM_STATS_EN.
- Defined: adds output port accept_count (16 bits). It increments by 1 on every acc cycle, saturates at 16'hFFFF (no wrap), and resets to 0 on reset.
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: hold reset=1 for 2 cycles, release. Required: out_valid=4'b0000, out_data=0, in_ready=1 for any in_sel.
- Single route: in_data=32'hDEADBEEF, in_sel=2, in_valid=1 for one cycle, out_ready=4'b0000. Required: next cycle out_valid=4'b0100 and channel 2 data=32'hDEADBEEF. With in_sel=2, in_ready=0; with in_sel=0, in_ready=1.
- Back-to-back streaming: channel 1 with out_ready[1]=1, words 1..8 on consecutive cycles. Required: in_ready stays 1 throughout, and channel 1 outputs 1..8 on 8 consecutive cycles, each 1 cycle after its accept.
- Stall and release: channel 3 full with 32'hA5A5A5A5, out_ready[3]=0 for 5 cycles, next word 32'h5A5A5A5A offered to channel 3. Required: data held stable and in_ready=0 during the stall. Asserting out_ready[3] accepts the new word in that same cycle, and the next cycle shows 32'h5A5A5A5A.
- Isolation: channel 0 stalled full, words to channels 1 and 2 alternating, their out_ready=1. Required: every alternating word is accepted and delivered, and channel 0 data is unchanged.
- Reset mid-operation: all four channels full, assert reset one cycle. Required: out_valid=4'b0000 next cycle, and no held word is emitted. With DEMUX_STREAM_STATS_EN defined, accept_count=0 after reset, and after 70000 accepts accept_count=16'hFFFF.
